nubus_mem_arbiter: RTL and testbench

NUBUS_MEM_ARBITER -- requirements
Module: nubus_mem_arbiter

---
 rtl/nubus_arb_pkg.sv | 28 ++
 rtl/nubus_arb_wdt.sv | 32 +++
 rtl/nubus_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_nubus_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_arb_pkg.sv
// Shared types for the NuBus / local CPU memory arbiter.
// Holds the FSM state encoding, the requester indices and the latched request record.
package nubus_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } arb_state_t;

    localparam logic REQ_NUBUS = 1'b0;
    localparam logic REQ_CPU   = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  write;
    } mem_req_t;

    // On a tie the requester that was not served last wins.
    function automatic logic pick_winner(input logic v0, input logic v1, input logic last_served);
        if (v0 && v1) begin
            return ~last_served;
        end
        return v1 ? REQ_CPU : REQ_NUBUS;
    endfunction

endpackage

// File: rtl/nubus_arb_wdt.sv
// Memory watchdog for the arbiter: counts BUSY cycles without mem_ready.
// expire fires in the stalled cycle whose increment brings the count to its all-ones value.
module nubus_arb_wdt
    import nubus_arb_pkg::*;
#(
    parameter int WDT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
    localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};

    logic [WDT_W-1:0] count;

    assign expire = en && (count == WDT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WDT_ONE;
        end
    end

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Two-requester arbiter (NuBus slave path and local CPU) in front of a single memory port.
// One transaction in flight at a time, round-robin on ties, watchdog abort on a stalled memory.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate and latch the winner's request
//   BUSY   | request presented on mem_*; wait for mem_ready or watchdog expiry
//   DONE   | one-cycle sX_ready pulse to the owner; response already registered
module nubus_mem_arbiter
    import nubus_arb_pkg::*;
#(
    parameter int WDT_W = 8
) (
    input  logic        nub_clk,
    input  logic        nub_reset,

    input  logic        s0_valid,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_write,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    output logic        s0_error,
    output logic        s0_tryagain,

    input  logic        s1_valid,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_write,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        s1_error,
    output logic        s1_tryagain,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    input  logic        mem_tryagain,

    output logic        arb_owner,
    output logic        arb_busy
);

    arb_state_t state;
    logic       last_served;
    mem_req_t   req_q;

    logic        grant;
    logic        winner;
    logic        wdt_en;
    logic        wdt_expire;
    logic        complete;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        resp_tryagain;

    assign grant  = (state == S_IDLE) && (s0_valid || s1_valid);
    assign winner = pick_winner(s0_valid, s1_valid, last_served);
    assign wdt_en = (state == S_BUSY) && !mem_ready;

    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_write = req_q.write;

    // A real memory response beats the watchdog, even in the terminal cycle.
    always_comb begin
        complete      = (state == S_BUSY) && (mem_ready || wdt_expire);
        resp_rdata    = '0;
        resp_error    = 1'b1;
        resp_tryagain = 1'b0;
        if (mem_ready) begin
            resp_rdata    = mem_rdata;
            resp_error    = mem_error;
            resp_tryagain = mem_tryagain;
        end
    end

    nubus_arb_wdt #(
        .WDT_W (WDT_W)
    ) u_wdt (
        .clk    (nub_clk),
        .rst    (nub_reset),
        .clr    (grant),
        .en     (wdt_en),
        .expire (wdt_expire)
    );

    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            state       <= S_IDLE;
            last_served <= REQ_CPU;
            arb_owner   <= REQ_NUBUS;
            arb_busy    <= 1'b0;
            mem_valid   <= 1'b0;
            req_q       <= '0;
            s0_ready    <= 1'b0;
            s0_rdata    <= '0;
            s0_error    <= 1'b0;
            s0_tryagain <= 1'b0;
            s1_ready    <= 1'b0;
            s1_rdata    <= '0;
            s1_error    <= 1'b0;
            s1_tryagain <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        arb_owner <= winner;
                        if (winner == REQ_CPU) begin
                            req_q <= '{addr: s1_addr, wdata: s1_wdata, write: s1_write};
                        end else begin
                            req_q <= '{addr: s0_addr, wdata: s0_wdata, write: s0_write};
                        end
                        mem_valid <= 1'b1;
                        arb_busy  <= 1'b1;
                        state     <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (complete) begin
                        if (arb_owner == REQ_NUBUS) begin
                            s0_ready    <= 1'b1;
                            s0_rdata    <= resp_rdata;
                            s0_error    <= resp_error;
                            s0_tryagain <= resp_tryagain;
                        end else begin
                            s1_ready    <= 1'b1;
                            s1_rdata    <= resp_rdata;
                            s1_error    <= resp_error;
                            s1_tryagain <= resp_tryagain;
                        end
                        mem_valid <= 1'b0;
                        arb_busy  <= 1'b0;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    s0_ready    <= 1'b0;
                    s1_ready    <= 1'b0;
                    last_served <= arb_owner;
                    state       <= S_IDLE;
                end

                default: begin
                    mem_valid <= 1'b0;
                    arb_busy  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Self-checking bench for nubus_mem_arbiter (WDT_W=4): table of single transactions
// plus hand-written tie, watchdog, mid-transaction reset and request-perturbation sequences.
module tb_nubus_mem_arbiter;

    logic        nub_clk;
    logic        nub_reset;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic [3:0]  s0_write, s1_write;
    logic        s0_ready, s0_error, s0_tryagain;
    logic        s1_ready, s1_error, s1_tryagain;
    logic [31:0] s0_rdata, s1_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_write;
    logic        mem_ready, mem_error, mem_tryagain;
    logic [31:0] mem_rdata;
    logic        arb_owner, arb_busy;

    int checks   = 0;
    int failures = 0;

    // Expected per-requester response registers.
    logic [31:0] m_rdata [2];
    logic        m_err   [2];
    logic        m_try   [2];

    nubus_mem_arbiter #(.WDT_W(4)) dut (
        .nub_clk      (nub_clk),
        .nub_reset    (nub_reset),
        .s0_valid     (s0_valid),
        .s0_addr      (s0_addr),
        .s0_wdata     (s0_wdata),
        .s0_write     (s0_write),
        .s0_ready     (s0_ready),
        .s0_rdata     (s0_rdata),
        .s0_error     (s0_error),
        .s0_tryagain  (s0_tryagain),
        .s1_valid     (s1_valid),
        .s1_addr      (s1_addr),
        .s1_wdata     (s1_wdata),
        .s1_write     (s1_write),
        .s1_ready     (s1_ready),
        .s1_rdata     (s1_rdata),
        .s1_error     (s1_error),
        .s1_tryagain  (s1_tryagain),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .mem_error    (mem_error),
        .mem_tryagain (mem_tryagain),
        .arb_owner    (arb_owner),
        .arb_busy     (arb_busy)
    );

    initial nub_clk = 1'b0;
    always #5 nub_clk = ~nub_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ready_of(input int w);
        return (w == 1) ? s1_ready : s0_ready;
    endfunction
    function automatic logic [31:0] rdata_of(input int w);
        return (w == 1) ? s1_rdata : s0_rdata;
    endfunction
    function automatic logic err_of(input int w);
        return (w == 1) ? s1_error : s0_error;
    endfunction
    function automatic logic try_of(input int w);
        return (w == 1) ? s1_tryagain : s0_tryagain;
    endfunction

    task automatic set_req(input int w, input logic v, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wr);
        if (w == 1) begin
            s1_valid = v; s1_addr = a; s1_wdata = wd; s1_write = wr;
        end else begin
            s0_valid = v; s0_addr = a; s0_wdata = wd; s0_write = wr;
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            m_rdata[w] = '0; m_err[w] = 1'b0; m_try[w] = 1'b0;
        end
    endtask

    task automatic chk_resp(input string tag);
        for (int w = 0; w < 2; w++) begin
            chk({tag, "_rdata"}, rdata_of(w), m_rdata[w]);
            chk({tag, "_error"}, 32'(err_of(w)), 32'(m_err[w]));
            chk({tag, "_tryagain"}, 32'(try_of(w)), 32'(m_try[w]));
        end
    endtask

    task automatic do_reset();
        nub_reset = 1'b1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        mem_ready = 1'b0; mem_rdata = '0; mem_error = 1'b0; mem_tryagain = 1'b0;
        repeat (2) @(negedge nub_clk);
        model_clear();
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_arb_owner", 32'(arb_owner), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_s0_ready", 32'(s0_ready), 0);
        chk("rst_s1_ready", 32'(s1_ready), 0);
        chk_resp("rst");
        nub_reset = 1'b0;
    endtask

    // One transaction from requester w; memory answers dly cycles after mem_valid rises.
    task automatic do_txn(input int w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wr,
                          input int dly, input logic [31:0] rd, input logic er, input logic ta,
                          input bit pert, input logic [31:0] x_rdata, input logic x_err, input logic x_try);
        set_req(w, 1'b1, a, wd, wr);
        @(negedge nub_clk);
        chk("grant_mem_valid", 32'(mem_valid), 1);
        chk("grant_arb_busy", 32'(arb_busy), 1);
        chk("grant_owner", 32'(arb_owner), 32'(w));
        chk("grant_mem_addr", mem_addr, a);
        chk("grant_mem_wdata", mem_wdata, wd);
        chk("grant_mem_write", 32'(mem_write), 32'(wr));
        for (int i = 0; i < dly; i++) begin
            if (pert && i == 0) set_req(w, 1'b0, ~a, ~wd, ~wr);
            @(negedge nub_clk);
            chk("busy_mem_valid", 32'(mem_valid), 1);
            chk("busy_mem_addr", mem_addr, a);
            chk("busy_mem_wdata", mem_wdata, wd);
            chk("busy_early_ready", 32'(ready_of(w)), 0);
        end
        mem_ready = 1'b1; mem_rdata = rd; mem_error = er; mem_tryagain = ta;
        @(negedge nub_clk);
        mem_ready = 1'b0; mem_rdata = 32'hA5A5_A5A5; mem_error = 1'b1; mem_tryagain = 1'b1;
        m_rdata[w] = x_rdata; m_err[w] = x_err; m_try[w] = x_try;
        chk("done_owner_ready", 32'(ready_of(w)), 1);
        chk("done_other_ready", 32'(ready_of(1 - w)), 0);
        chk("done_mem_valid", 32'(mem_valid), 0);
        chk("done_arb_busy", 32'(arb_busy), 0);
        chk_resp("done");
        set_req(w, 1'b0, '0, '0, '0);
        @(negedge nub_clk);
        chk("idle_owner_ready", 32'(ready_of(w)), 0);
        chk("idle_mem_valid", 32'(mem_valid), 0);
        chk_resp("idle");
    endtask

    typedef struct {
        int          who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  write;
        int          dly;
        logic [31:0] m_rdata;
        logic        m_error;
        logic        m_try;
        bit          pert;
        logic [31:0] x_rdata;
        logic        x_error;
        logic        x_try;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 32'hF000_0010, 32'h0000_0000, 4'h0, 3,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[1] = '{1, 32'h0000_1000, 32'h1234_5678, 4'hF, 0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2] = '{0, 32'hF000_0020, 32'h0000_0000, 4'h0, 1,  32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1};
        vecs[3] = '{1, 32'h0000_2000, 32'h0000_0000, 4'h0, 2,  32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[4] = '{0, 32'hF000_0030, 32'h0000_0000, 4'h0, 14, 32'h55AA_55AA, 1'b0, 1'b0, 1'b0, 32'h55AA_55AA, 1'b0, 1'b0};
        vecs[5] = '{0, 32'hF000_0040, 32'hAABB_CCDD, 4'h3, 4,  32'h1111_2222, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0};

        do_reset();

        // Tie after reset: s0, then s1, then s0 again.
        set_req(0, 1'b1, 32'hF000_0100, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
        @(negedge nub_clk);
        chk("tie1_owner", 32'(arb_owner), 0);
        chk("tie1_mem_addr", mem_addr, 32'hF000_0100);
        mem_ready = 1'b1; mem_rdata = 32'h0000_00A0;
        @(negedge nub_clk);
        mem_ready = 1'b0;
        chk("tie1_s0_ready", 32'(s0_ready), 1);
        chk("tie1_s1_ready", 32'(s1_ready), 0);
        chk("tie1_s0_rdata", s0_rdata, 32'h0000_00A0);
        s0_valid = 1'b0;
        @(negedge nub_clk);
        chk("tie_idle_mem_valid", 32'(mem_valid), 0);
        @(negedge nub_clk);
        chk("tie2_owner", 32'(arb_owner), 1);
        chk("tie2_mem_valid", 32'(mem_valid), 1);
        chk("tie2_mem_addr", mem_addr, 32'h0000_0200);
        mem_ready = 1'b1; mem_rdata = 32'h0000_00B1;
        @(negedge nub_clk);
        mem_ready = 1'b0;
        chk("tie2_s1_ready", 32'(s1_ready), 1);
        chk("tie2_s0_ready", 32'(s0_ready), 0);
        chk("tie2_s1_rdata", s1_rdata, 32'h0000_00B1);
        set_req(0, 1'b1, 32'hF000_0300, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
        @(negedge nub_clk);
        chk("tie3_idle_mem_valid", 32'(mem_valid), 0);
        @(negedge nub_clk);
        chk("tie3_owner", 32'(arb_owner), 0);
        chk("tie3_mem_addr", mem_addr, 32'hF000_0300);
        mem_ready = 1'b1; mem_rdata = 32'h0000_00C2;
        @(negedge nub_clk);
        mem_ready = 1'b0;
        chk("tie3_s0_ready", 32'(s0_ready), 1);
        chk("tie3_s1_ready", 32'(s1_ready), 0);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        m_rdata[0] = 32'h0000_00C2; m_rdata[1] = 32'h0000_00B1;
        @(negedge nub_clk);
        chk_resp("tie_end");

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].who, vecs[i].addr, vecs[i].wdata, vecs[i].write, vecs[i].dly,
                   vecs[i].m_rdata, vecs[i].m_error, vecs[i].m_try, vecs[i].pert,
                   vecs[i].x_rdata, vecs[i].x_error, vecs[i].x_try);
        end

        // Watchdog: memory never answers an s1 write.
        begin
            int busy_cycles = 0;
            bit seen = 1'b0;
            set_req(1, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF);
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge nub_clk);
                if (s1_ready) seen = 1'b1;
                else if (mem_valid) busy_cycles++;
            end
            chk("wdt_ready_seen", 32'(seen), 1);
            chk("wdt_busy_cycles", 32'(busy_cycles), 15);
            chk("wdt_done_mem_valid", 32'(mem_valid), 0);
            chk("wdt_s0_ready", 32'(s0_ready), 0);
            m_rdata[1] = '0; m_err[1] = 1'b1; m_try[1] = 1'b0;
            chk_resp("wdt");
            set_req(1, 1'b0, '0, '0, '0);
            @(negedge nub_clk);
        end

        // Reset two cycles into BUSY abandons the transaction.
        set_req(0, 1'b1, 32'hF000_0050, 32'h0, 4'h0);
        @(negedge nub_clk);
        @(negedge nub_clk);
        chk("rstmid_busy", 32'(mem_valid), 1);
        nub_reset = 1'b1;
        @(negedge nub_clk);
        chk("rstmid_mem_valid", 32'(mem_valid), 0);
        chk("rstmid_arb_busy", 32'(arb_busy), 0);
        chk("rstmid_s0_ready", 32'(s0_ready), 0);
        nub_reset = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge nub_clk);
            chk("rstmid_no_ready", 32'(s0_ready | s1_ready), 0);
            chk("rstmid_idle", 32'(mem_valid), 0);
        end
        chk_resp("rstmid");
        do_txn(1, 32'h0000_5000, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b0, 1'b0, 1'b0,
               32'h7777_8888, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
